// File: rtl/axis_counter_checker.sv
// axis_counter_checker: AXI4-Stream sink that checks an incrementing counter
// stream for data sequence, all-ones strobes and tlast framing, counts the
// erroneous beats and captures the first mismatch. Reports pass/fail once
// NUM_FRAMES frames have been received.
// Optional feature: define CHECKER_BACKPRESSURE_EN to throttle tready with a
// 16-bit LFSR (about 25% stall cycles); checking itself is unchanged.
module axis_counter_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int FRAME_LEN  = 256,
    parameter int NUM_FRAMES = 16,
    parameter logic [DATA_WIDTH-1:0] START_VALUE = '0
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_areset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tvalid,
    output logic                    s00_axis_tready,
    input  logic                    s00_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [31:0]             beat_count,
    output logic                    first_err_valid,
    output logic [DATA_WIDTH-1:0]   first_err_data,
    output logic [DATA_WIDTH-1:0]   first_err_expected
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BIW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FCW    = $clog2(NUM_FRAMES + 1);
    localparam logic [BIW-1:0] LAST_IDX   = BIW'(FRAME_LEN - 1);
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q;
    logic                    tready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [15:0]             err_count_q;
    logic [31:0]             beat_count_q;
    logic                    fe_valid_q;
    logic [DATA_WIDTH-1:0]   fe_data_q;
    logic [DATA_WIDTH-1:0]   fe_exp_q;
    logic [DATA_WIDTH-1:0]   expected_q;
    logic [BIW-1:0]          beat_idx_q;
    logic [FCW-1:0]          frame_cnt_q;

    logic                    accept;
    logic                    last_slot;
    logic                    beat_err;
    logic                    frame_end;
    logic                    final_frame;
    logic [15:0]             err_count_d;

`ifdef CHECKER_BACKPRESSURE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
`endif

    // Per-beat check: any failing rule marks the beat once; the frame ends on
    // tlast or on the last slot, whichever comes first.
    always_comb begin
        accept      = s00_axis_tvalid & tready_q;
        last_slot   = (beat_idx_q == LAST_IDX);
        beat_err    = (s00_axis_tdata != expected_q) ||
                      (s00_axis_tstrb != {STRB_W{1'b1}}) ||
                      (s00_axis_tlast != last_slot);
        frame_end   = s00_axis_tlast | last_slot;
        final_frame = frame_end & (frame_cnt_q == LAST_FRAME);
        err_count_d = (beat_err && (err_count_q != 16'hFFFF)) ?
                      err_count_q + 16'd1 : err_count_q;
    end

    // Control FSM and statistics; expected value resyncs to every accepted beat.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q      <= S_IDLE;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            beat_count_q <= '0;
            fe_valid_q   <= 1'b0;
            fe_data_q    <= '0;
            fe_exp_q     <= '0;
            expected_q   <= '0;
            beat_idx_q   <= '0;
            frame_cnt_q  <= '0;
`ifdef CHECKER_BACKPRESSURE_EN
            lfsr_q       <= LFSR_SEED;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
`ifdef CHECKER_BACKPRESSURE_EN
                    lfsr_q   <= lfsr_d;
                    tready_q <= (lfsr_d[1:0] != 2'b00);
`endif
                    if (accept) begin
                        expected_q   <= s00_axis_tdata + DATA_WIDTH'(1);
                        beat_count_q <= beat_count_q + 32'd1;
                        err_count_q  <= err_count_d;
                        if (beat_err && !fe_valid_q) begin
                            fe_valid_q <= 1'b1;
                            fe_data_q  <= s00_axis_tdata;
                            fe_exp_q   <= expected_q;
                        end
                        if (frame_end) begin
                            beat_idx_q  <= '0;
                            frame_cnt_q <= frame_cnt_q + FCW'(1);
                        end else begin
                            beat_idx_q  <= beat_idx_q + BIW'(1);
                        end
                        if (final_frame) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (err_count_d == 16'd0);
                            tready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        err_count_q  <= '0;
                        beat_count_q <= '0;
                        fe_valid_q   <= 1'b0;
                        fe_data_q    <= '0;
                        fe_exp_q     <= '0;
                        expected_q   <= START_VALUE;
                        beat_idx_q   <= '0;
                        frame_cnt_q  <= '0;
`ifdef CHECKER_BACKPRESSURE_EN
                        lfsr_q       <= LFSR_SEED;
                        tready_q     <= (LFSR_SEED[1:0] != 2'b00);
`else
                        tready_q     <= 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    assign s00_axis_tready    = tready_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_count_q;
    assign beat_count         = beat_count_q;
    assign first_err_valid    = fe_valid_q;
    assign first_err_data     = fe_data_q;
    assign first_err_expected = fe_exp_q;
endmodule
